// File: rtl/sobel_window_gen_if.sv
// Pixel-stream in / 3x3 window out bundle for sobel_window_gen.
//   in_valid, in_sof, in_pixel : raster pixel stream (no backpressure)
//   p0..p8 (no p4)             : neighbour pixels of the emitted window
//   out_valid, out_x, out_y    : window qualifier and center coordinates
//   out_eof                    : last window of the frame
// slave  : view of the window generator
// master : view of the pixel source / window consumer
interface sobel_window_gen_if;
    logic        in_valid;
    logic        in_sof;
    logic [7:0]  in_pixel;
    logic [7:0]  p0, p1, p2, p3, p5, p6, p7, p8;
    logic        out_valid;
    logic [15:0] out_x;
    logic [15:0] out_y;
    logic        out_eof;

    modport slave (
        input  in_valid, in_sof, in_pixel,
        output p0, p1, p2, p3, p5, p6, p7, p8, out_valid, out_x, out_y, out_eof
    );

    modport master (
        output in_valid, in_sof, in_pixel,
        input  p0, p1, p2, p3, p5, p6, p7, p8, out_valid, out_x, out_y, out_eof
    );
endinterface

// File: rtl/sobel_window_gen.sv
// Raster-to-window front end for the Sobel core. Accepts one pixel per cycle, keeps the two
// previous lines in line buffers and emits the eight neighbours of every interior 3x3 window.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : sobel_window_gen_if.slave (pixel stream in, registered window out)
module sobel_window_gen #(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480
) (
    input logic               clk,
    input logic               rst,
    sobel_window_gen_if.slave bus
);
    localparam int unsigned ColW    = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [15:0] LastCol = 16'(IMG_WIDTH - 1);
    localparam logic [15:0] LastRow = 16'(IMG_HEIGHT - 1);

    typedef enum logic [0:0] {StWaitSof, StActive} state_e;

    state_e      state_q, state_d;
    logic [15:0] col_q, col_d, row_q, row_d;

    // Line buffers: lb1 holds row r-1, lb2 holds row r-2. Never reset.
    logic [7:0] lb1 [IMG_WIDTH];
    logic [7:0] lb2 [IMG_WIDTH];

    logic            accept, emit, last_pix;
    logic [15:0]     cur_col, cur_row;
    logic [ColW-1:0] lb_idx;
    logic [7:0]      lb_a, lb_b;

    // Two most recent accepted columns: c1 = column c-1, c2 = column c-2 (top, mid, bottom).
    logic [7:0] c1_top_q, c1_mid_q, c1_bot_q;
    logic [7:0] c2_top_q, c2_mid_q, c2_bot_q;

    logic [7:0]  p0_q, p1_q, p2_q, p3_q, p5_q, p6_q, p7_q, p8_q;
    logic        out_valid_q, out_eof_q;
    logic [15:0] out_x_q, out_y_q;

    always_comb begin
        accept   = bus.in_valid && (bus.in_sof || state_q == StActive);
        // sof resynchronises: the pixel is (0,0) whatever the counters say
        cur_col  = bus.in_sof ? 16'd0 : col_q;
        cur_row  = bus.in_sof ? 16'd0 : row_q;
        lb_idx   = cur_col[ColW-1:0];
        lb_a     = lb1[lb_idx];
        lb_b     = lb2[lb_idx];
        last_pix = (cur_col == LastCol) && (cur_row == LastRow);
        emit     = accept && (cur_col >= 16'd2) && (cur_row >= 16'd2);

        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        if (accept) begin
            state_d = StActive;
            row_d   = cur_row;
            if (cur_col == LastCol) begin
                col_d = 16'd0;
                if (cur_row == LastRow) begin
                    row_d   = 16'd0;
                    state_d = StWaitSof;
                end else begin
                    row_d = cur_row + 16'd1;
                end
            end else begin
                col_d = cur_col + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StWaitSof;
            col_q   <= 16'd0;
            row_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    // Read (combinational above) happens before this write in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            lb1[lb_idx] <= bus.in_pixel;
            lb2[lb_idx] <= lb_a;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {c1_top_q, c1_mid_q, c1_bot_q} <= '0;
            {c2_top_q, c2_mid_q, c2_bot_q} <= '0;
            {p0_q, p1_q, p2_q, p3_q, p5_q, p6_q, p7_q, p8_q} <= '0;
            out_valid_q <= 1'b0;
            out_eof_q   <= 1'b0;
            out_x_q     <= 16'd0;
            out_y_q     <= 16'd0;
        end else begin
            out_valid_q <= emit;
            out_eof_q   <= emit && last_pix;
            if (accept) begin
                {c2_top_q, c2_mid_q, c2_bot_q} <= {c1_top_q, c1_mid_q, c1_bot_q};
                {c1_top_q, c1_mid_q, c1_bot_q} <= {lb_b, lb_a, bus.in_pixel};
            end
            // Output registers load only on emission so they hold between windows.
            if (emit) begin
                p0_q    <= c2_top_q;
                p1_q    <= c1_top_q;
                p2_q    <= lb_b;
                p3_q    <= c2_mid_q;
                p5_q    <= lb_a;
                p6_q    <= c2_bot_q;
                p7_q    <= c1_bot_q;
                p8_q    <= bus.in_pixel;
                out_x_q <= cur_col - 16'd1;
                out_y_q <= cur_row - 16'd1;
            end
        end
    end

    assign bus.p0        = p0_q;
    assign bus.p1        = p1_q;
    assign bus.p2        = p2_q;
    assign bus.p3        = p3_q;
    assign bus.p5        = p5_q;
    assign bus.p6        = p6_q;
    assign bus.p7        = p7_q;
    assign bus.p8        = p8_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_eof   = out_eof_q;
    assign bus.out_x     = out_x_q;
    assign bus.out_y     = out_y_q;
endmodule

// File: tb/tb_sobel_window_gen.sv
// Self-checking bench for sobel_window_gen on a 5x4 image: a frame-array reference model checks
// every cycle, a hand-written window table checks the test-plan frames, and short sequences
// cover junk-before-sof, gaps, back-to-back frames, mid-frame sof and mid-frame reset.
module tb_sobel_window_gen;
    localparam int W = 5;
    localparam int H = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sobel_window_gen_if bus ();

    sobel_window_gen #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [63:0] p;
        logic        eof;
    } win_t;

    // Table record: input = window center, expected = neighbour pixels and eof.
    typedef struct {
        logic [15:0] cx;
        logic [15:0] cy;
        logic [63:0] p;
        logic        eof;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit          m_active = 1'b0;
    int          m_col = 0;
    int          m_row = 0;
    logic [7:0]  img [H][W];
    logic        e_valid = 1'b0;
    logic        e_eof = 1'b0;
    logic [15:0] e_x = '0;
    logic [15:0] e_y = '0;
    logic [63:0] e_p = '0;

    win_t got[$];
    bit   prev_valid = 1'b0;
    int   consec = 0;
    vec_t tbl [6];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] dut_vec();
        return {30'd0, bus.out_valid, bus.out_eof, bus.out_x, bus.out_y,
                bus.p0, bus.p1, bus.p2, bus.p3, bus.p5, bus.p6, bus.p7, bus.p8};
    endfunction

    task automatic step(input logic v, input logic s, input logic [7:0] pix, input logic r);
        @(negedge clk);
        bus.in_valid = v;
        bus.in_sof   = s;
        bus.in_pixel = pix;
        rst          = r;
        if (r) begin
            m_active = 1'b0; m_col = 0; m_row = 0;
            e_valid = 1'b0; e_eof = 1'b0; e_x = '0; e_y = '0; e_p = '0;
        end else begin
            e_valid = 1'b0;
            e_eof   = 1'b0;
            if (v && (s || m_active)) begin
                if (s) begin
                    m_col = 0;
                    m_row = 0;
                end
                img[m_row][m_col] = pix;
                if (m_col >= 2 && m_row >= 2) begin
                    e_valid = 1'b1;
                    e_x     = 16'(m_col - 1);
                    e_y     = 16'(m_row - 1);
                    e_eof   = (m_col == W - 1) && (m_row == H - 1);
                    e_p = {img[m_row-2][m_col-2], img[m_row-2][m_col-1], img[m_row-2][m_col],
                           img[m_row-1][m_col-2], img[m_row-1][m_col],
                           img[m_row][m_col-2], img[m_row][m_col-1], img[m_row][m_col]};
                end
                m_active = 1'b1;
                m_col++;
                if (m_col == W) begin
                    m_col = 0;
                    m_row++;
                    if (m_row == H) begin
                        m_row = 0;
                        m_active = 1'b0;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        chk("cycle", dut_vec(), {30'd0, e_valid, e_eof, e_x, e_y, e_p});
        if (bus.out_valid) begin
            got.push_back('{x: bus.out_x, y: bus.out_y, eof: bus.out_eof,
                            p: {bus.p0, bus.p1, bus.p2, bus.p3, bus.p5, bus.p6, bus.p7, bus.p8}});
            if (prev_valid) consec++;
        end
        prev_valid = bus.out_valid;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 8'($urandom), 1'b0);
    endtask

    // gap: 0 none, 1 idle after every pixel, 2 random idles before each pixel
    task automatic send_frame(input logic [7:0] base, input int gap, input bit rnd);
        logic [7:0] v;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                v = rnd ? 8'($urandom) : base + 8'(16 * r + c);
                if (gap == 2) repeat ($urandom_range(0, 2)) idle();
                step(1'b1, (r == 0 && c == 0), v, 1'b0);
                if (gap == 1) idle();
            end
        end
    endtask

    task automatic send_partial(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++)
            step(1'b1, (i == 0), base + 8'(16 * (i / W) + (i % W)), 1'b0);
    endtask

    task automatic check_table(input string tag, input int start);
        chk({tag, "_count"}, 128'(got.size()), 128'(start + 6));
        if (got.size() >= start + 6) begin
            for (int i = 0; i < 6; i++)
                chk($sformatf("%s_win%0d", tag, i),
                    {got[start+i].x, got[start+i].y, got[start+i].p, 31'd0, got[start+i].eof},
                    {tbl[i].cx, tbl[i].cy, tbl[i].p, 31'd0, tbl[i].eof});
        end
    endtask

    initial begin
        int eofs;
        tbl[0] = '{cx: 16'd1, cy: 16'd1, p: 64'h00_01_02_10_12_20_21_22, eof: 1'b0};
        tbl[1] = '{cx: 16'd2, cy: 16'd1, p: 64'h01_02_03_11_13_21_22_23, eof: 1'b0};
        tbl[2] = '{cx: 16'd3, cy: 16'd1, p: 64'h02_03_04_12_14_22_23_24, eof: 1'b0};
        tbl[3] = '{cx: 16'd1, cy: 16'd2, p: 64'h10_11_12_20_22_30_31_32, eof: 1'b0};
        tbl[4] = '{cx: 16'd2, cy: 16'd2, p: 64'h11_12_13_21_23_31_32_33, eof: 1'b0};
        tbl[5] = '{cx: 16'd3, cy: 16'd2, p: 64'h12_13_14_22_24_32_33_34, eof: 1'b1};

        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_pixel = 8'h00;
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b1, 8'h99, 1'b1);
        chk("reset_outputs", dut_vec(), 128'd0);
        idle();

        // Basic frame, continuous
        got.delete();
        send_frame(8'h00, 0, 1'b0);
        idle();
        check_table("basic", 0);

        // Gapped frame
        got.delete();
        consec = 0;
        send_frame(8'h00, 1, 1'b0);
        check_table("gaps", 0);
        chk("gaps_no_consecutive", 128'(consec), 128'd0);

        // Junk before sof
        got.delete();
        repeat (3) step(1'b1, 1'b0, 8'h77, 1'b0);
        send_frame(8'h00, 0, 1'b0);
        idle();
        check_table("junk", 0);

        // Back-to-back frames
        got.delete();
        send_frame(8'h00, 0, 1'b0);
        send_frame(8'h80, 0, 1'b0);
        idle();
        chk("b2b_count", 128'(got.size()), 128'd12);
        if (got.size() == 12) begin
            chk("b2b_p0", 128'(got[6].p[63:56]), 128'h80);
            chk("b2b_p8", 128'(got[6].p[7:0]), 128'hA2);
            chk("b2b_y", 128'(got[6].y), 128'd1);
        end
        eofs = 0;
        foreach (got[i]) if (got[i].eof) eofs++;
        chk("b2b_eofs", 128'(eofs), 128'd2);

        // sof at pixel (3,2) of a partial frame
        got.delete();
        send_partial(8'h40, 2 * W + 3);
        send_frame(8'h00, 0, 1'b0);
        idle();
        check_table("resync", 1);

        // reset at pixel (3,2)
        got.delete();
        send_partial(8'h40, 2 * W + 3);
        step(1'b1, 1'b0, 8'h55, 1'b1);
        chk("midrst_outputs", dut_vec(), 128'd0);
        repeat (3) step(1'b1, 1'b0, 8'h66, 1'b0);
        send_frame(8'h00, 0, 1'b0);
        idle();
        check_table("midrst", 1);

        // Random frames with random gaps and junk, checked cycle by cycle against the model
        for (int f = 0; f < 6; f++) begin
            got.delete();
            repeat ($urandom_range(0, 3)) step(1'b1, 1'b0, 8'($urandom), 1'b0);
            send_frame(8'h00, 2, 1'b1);
            idle();
            chk($sformatf("rand%0d_count", f), 128'(got.size()), 128'd6);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
